// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: shared TX engine state encoding and baud divisor derivation
package uart_tx_buffered_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter with restart, one-cycle bit_done at CLKS_PER_BIT-1
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 234,
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);
  logic [CW-1:0] cnt;
  assign bit_done = !restart && cnt == CW'(CLKS_PER_BIT - 1);
  // count bit time, wrapping at the end of every bit so consecutive bits stay aligned
  always_ff @(posedge clk)
    if (reset || restart) cnt <= '0;
    else cnt <= bit_done ? '0 : cnt + CW'(1);
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: circular byte buffer drained as 8N1 frames (8E1 with UART_TX_PARITY_EN)
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD = 115_200,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t state, state_n;
  logic [7:0] data_q, data_n;
  logic [2:0] idx, idx_n;
  logic pop, push, bit_done, tx_n;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign push = wr_en && !full;
  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk(clk),
    .reset(reset),
    .restart(state == IDLE),
    .bit_done(bit_done)
  );
  // buffer storage: no reset, contents are only meaningful between the pointers
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and sticky overflow (a dropped write beats clr_ovf)
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= (wr_en && full) || (overflow && !clr_ovf);
    end
  // engine state, held byte, bit index and registered line
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      data_q <= '0;
      idx <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      data_q <= data_n;
      idx <= idx_n;
      tx <= tx_n;
    end
  // frame sequencing; the line value is derived from the next state so tx changes with it
  always_comb begin
    state_n = state;
    data_n = data_q;
    idx_n = idx;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop = 1'b1;
          data_n = mem[rd_ptr];
          state_n = START;
        end
      START:
        if (bit_done) begin
          state_n = DATA;
          idx_n = '0;
        end
      DATA:
        if (bit_done) begin
          idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx == 3'd7) state_n = PARITY;
`else
          if (idx == 3'd7) state_n = STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (bit_done) state_n = STOP;
`endif
      STOP:
        if (bit_done) begin
          if (!empty) begin
            pop = 1'b1;
            data_n = mem[rd_ptr];
            state_n = START;
          end else state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? data_q[idx_n] : state_n == PARITY ? ^data_q : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? data_q[idx_n] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized bench against a queue-and-timer frame model
module tb_uart_tx_buffered;
  localparam int CPB = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, busy, overflow, tx;
  logic [4:0] count;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q [$];
  int rem = 0;
  logic [7:0] cur = 8'h00;
  bit ovf_m = 1'b0;
  always #5 clk = ~clk;
  uart_tx_buffered #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_ovf(clr_ovf),
    .full(full),
    .empty(empty),
    .count(count),
    .busy(busy),
    .overflow(overflow),
    .tx(tx)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int tx_exp();
    int b;
    if (rem == 0) return 1;
    b = (FRAME - rem) / CPB;
    if (b == 0) return 0;
    if (b <= 8) return int'(cur[b-1]);
    if (NB == 11 && b == 9) return int'(^cur);
    return 1;
  endfunction
  task automatic step();
    int sz;
    bit drop;
    @(posedge clk);
    if (reset) begin
      q.delete();
      rem = 0;
      ovf_m = 1'b0;
    end else begin
      sz = q.size();
      drop = wr_en && sz == DEPTH;
      ovf_m = drop || (ovf_m && !clr_ovf);
      if (rem <= 1 && sz > 0) begin
        cur = q.pop_front();
        rem = FRAME;
      end else if (rem > 0) rem--;
      if (wr_en && !drop) q.push_back(wr_data);
    end
    @(negedge clk);
    check("tx", int'(tx), tx_exp());
    check("busy", int'(busy), int'(rem > 0));
    check("count", int'(count), q.size());
    check("full", int'(full), int'(q.size() == DEPTH));
    check("empty", int'(empty), int'(q.size() == 0));
    check("overflow", int'(overflow), int'(ovf_m));
  endtask
  task automatic idle(input int n);
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    repeat (n) step();
  endtask
  task automatic write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    reset = 1'b0;
    write(8'h55);
    idle(FRAME + 10);
    write(8'h41);
    write(8'h42);
    write(8'h43);
    idle(3 * FRAME + 20);
    write(8'h10);
    idle(2);
    for (int i = 0; i < 17; i++) write(8'(8'h20 + i));
    wr_en = 1'b1;
    wr_data = 8'hEE;
    clr_ovf = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    idle(3);
    idle(17 * FRAME + 20);
    write(8'hA5);
    idle(FRAME + 10);
    write(8'h07);
    idle(FRAME + 5);
    write(8'h03);
    idle(FRAME + 5);
    repeat (400) begin
      wr_en = $urandom_range(0, 9) == 0;
      wr_data = 8'($urandom);
      clr_ovf = $urandom_range(0, 30) == 0;
      step();
    end
    idle((DEPTH + 1) * FRAME + 10);
    write(8'hFF);
    idle(35);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(FRAME + 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
